clock_ratio_monitor: RTL and testbench
======================================

# clock_ratio_monitor

Measures an incoming slow clock-like signal against the local clock `clkin` and reports its period and high time in `clkin` cycles. It declares lock once the measured period is stable, and flags a timeout when the signal stops toggling. It is the receiving end of the clock-divider blocks: it checks a divided clock, for example divide-by-3, and recovers the division ratio and duty cycle for self-check and bring-up.

## Interface
- `CNT_W`, default 8: width of the period and high-time counters and outputs.
- `LOCK_COUNT`, default 4: number of consecutive equal period measurements required for lock.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `sig_in` (minimum 2).

Ports:
- `clkin`  input  1: the single clock; all logic is on its rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `sig_in`  input  1: monitored signal, treated as asynchronous.
- `period`  output  CNT_W: last measured rise-to-rise period, in clkin cycles.
- `high_time`  output  CNT_W: high time belonging to the reported period.
- `valid`  output  1: one-cycle pulse when `period` and `high_time` update.
- `locked`  output  1: high while the last LOCK_COUNT periods were equal.
- `timeout`  output  1: level; no rising edge seen for 2^CNT_W−1 cycles.

## Operation
- **Reset:** all outputs, counters, synchronizer flops and the state register clear to 0; state is WAIT.
- **Synchronizer:** `s` is the last synchronizer stage and `s_d` is `s` delayed by one flop.
  - rise = `s` & ~`s_d`
  - fall = ~`s` & `s_d`
- **Period counter `cnt`:** loads 1 on a rise cycle, otherwise increments, saturating at 2^CNT_W−1.
- **High counter `hcnt`:** loads 1 on a rise cycle; increments (saturating) while `s`=1; on fall, `hcnt` is copied to `h_cap`.
- **State machine** (states WAIT, FIRST, TRACK, LOCK):
  - WAIT: on rise → FIRST; no measurement is made.
  - FIRST: on rise → TRACK; capture `period`=`cnt` and `high_time`=`h_cap`; pulse `valid`; set match=1.
  - TRACK/LOCK: on each rise, capture and pulse `valid` as above.
    - If the new period equals the previous period, match = min(match+1, LOCK_COUNT); otherwise match = 1.
    - Next state is LOCK if match reaches LOCK_COUNT, else TRACK. A mismatch in LOCK therefore returns to TRACK.
  - Any state other than WAIT: if `cnt` is saturated and there is no rise, go to WAIT, set `timeout`=1 and `locked`=0, and clear `period`/`high_time` to 0 with no `valid` pulse.
- **`timeout`:** clears on the next rise.
- **`locked`:** equals (state == LOCK).
- **Minimum measurable period:** 2 (sig_in toggling every clkin cycle gives period=2, high_time=1).
- **Simultaneous rise and saturation:** the rise wins; the measurement reports 2^CNT_W−1.
- **Reset mid-operation:** everything returns to WAIT immediately, asynchronously; the first post-reset edge produces no `valid`.

## Timing
- A `sig_in` transition sampled at edge k is visible as `s` after SYNC_STAGES edges.
- rise/fall are combinational from `s`/`s_d`.
- `period`, `high_time`, `valid` and `locked` are registered: they update on the clock edge ending the rise cycle.
- Latency from sampled `sig_in` rise to `valid` is SYNC_STAGES+1 cycles.
- `valid` is exactly 1 cycle wide; `period`/`high_time` hold between pulses.
- `locked` rises in the same cycle as the `valid` of the LOCK_COUNT-th equal measurement; it falls in the same cycle as a mismatching `valid` or as `timeout` assertion.
- There is no back-pressure; the consumer must sample on `valid`.

## Structure
- **Shared package `clkmon_pkg`:**
  - state enum `clkmon_state_e` {WAIT, FIRST, TRACK, LOCK}
  - default-parameter constants
- **Sub-module `edge_sync`:** SYNC_STAGES-flop synchronizer plus delay flop, outputting `s`, rise and fall; async active-low reset.
- The top level holds the counters, capture registers and FSM.

## Test plan
- **Divide-by-3 input** (period 3 cycles, high 1): `valid` every 3 cycles with `period`=3, `high_time`=1; `locked`=1 at the 4th measurement.
- **Period 5, high 2:** `period`=5, `high_time`=2. Then switch to period 6: the first period-6 measurement drops `locked`, and `locked` returns after 4 equal period-6 measurements.
- **Toggle every cycle:** `period`=2, `high_time`=1, `valid` every 2 cycles, lock achieved.
- **Stop sig_in after lock:** 255 cycles after the last rise, `timeout`=1, `locked`=0, `period`=0. The next rise clears `timeout` with no `valid`; the following rise gives `valid`.
- **Assert `reset` mid-LOCK:** all outputs are 0 immediately. After release, the first rise gives no `valid`, and the second rise gives `valid` with the correct period.
- **sig_in pulse narrower than one clkin cycle, or a missed rise:** no `valid` and no X; the FSM stays consistent and the next measurement is correct.

Source files
------------

// File: rtl/clkmon_pkg.sv
// Shared types and default parameters for the clock ratio monitor.
package clkmon_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    FIRST = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } clkmon_state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, with edge detection
// against a one-cycle delayed copy of the synchronized level.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures period and high time of a slow asynchronous clock-like input in
// clkin cycles; reports lock on stable period and timeout when it stops.
//
//   state | meaning
//   WAIT  | no reference rise yet (after reset or timeout)
//   FIRST | one rise seen, next rise yields the first measurement
//   TRACK | measuring, period not yet stable for LOCK_COUNT measurements
//   LOCK  | last LOCK_COUNT measured periods were equal
module clock_ratio_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam int               MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);

  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] h_cap;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_nxt;
  clkmon_state_e    state;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clkin (clkin),
    .reset (reset),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  // Rise cycle counts as the first cycle of both the period and the high phase.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      hcnt  <= '0;
      h_cap <= '0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      if (rise)
        hcnt <= CNT_W'(1);
      else if (s && (hcnt != CNT_MAX))
        hcnt <= hcnt + 1'b1;

      if (fall)
        h_cap <= hcnt;
    end
  end

  always_comb begin
    match_nxt = MW'(1);
    if (cnt == period) begin
      if (match != MATCH_MAX)
        match_nxt = match + 1'b1;
      else
        match_nxt = MATCH_MAX;
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state     <= WAIT;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
      match     <= '0;
    end else begin
      valid <= 1'b0;
      if (rise)
        timeout <= 1'b0;

      case (state)
        WAIT: begin
          if (rise)
            state <= FIRST;
        end
        FIRST, TRACK, LOCK: begin
          if (rise) begin
            period    <= cnt;
            high_time <= h_cap;
            valid     <= 1'b1;
            if (state == FIRST) begin
              match  <= MW'(1);
              state  <= TRACK;
              locked <= 1'b0;
            end else begin
              match <= match_nxt;
              if (match_nxt == MATCH_MAX) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                state  <= TRACK;
                locked <= 1'b0;
              end
            end
          end else if (cnt == CNT_MAX) begin
            // Input stalled: drop the measurement and restart acquisition.
            state     <= WAIT;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            period    <= '0;
            high_time <= '0;
            match     <= '0;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor: a cycle-level model of the driven
// waveform queues expected measurements, a monitor pops them on each valid.
module tb_clock_ratio_monitor;
  import clkmon_pkg::*;

  localparam int CNT_W       = 8;
  localparam int LOCK_COUNT  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clkin = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  clock_ratio_monitor #(
    .CNT_W      (CNT_W),
    .LOCK_COUNT (LOCK_COUNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int   per;
    int   hi;
    logic lk;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;

  // waveform model state
  int m_seen, m_cnt, m_hcnt, m_last_per, m_run;
  bit m_prev;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clkin) begin
    if (reset === 1'b1 && valid === 1'b1) begin
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        check("spurious_valid", valid, 0);
      end else begin
        e = sb.pop_front();
        check("period", period, e.per);
        check("high_time", high_time, e.hi);
        check("locked_at_valid", locked, e.lk);
      end
    end
  end

  task automatic model_reset();
    m_seen = 0; m_cnt = 0; m_hcnt = 0; m_last_per = 0; m_run = 0; m_prev = 0;
  endtask

  // One sampled clkin cycle of sig_in, plus the expected-result model.
  task automatic drive_cycle(input bit v);
    exp_t x;
    @(posedge clkin);
    #2;
    sig_in = v;
    if (v && !m_prev) begin
      m_seen++;
      if (m_seen >= 2) begin
        x.per = m_cnt;
        x.hi  = m_hcnt;
        if (m_seen == 2)             m_run = 1;
        else if (x.per == m_last_per) m_run = (m_run < LOCK_COUNT) ? m_run + 1 : LOCK_COUNT;
        else                          m_run = 1;
        m_last_per = x.per;
        x.lk = (m_run == LOCK_COUNT);
        sb.push_back(x);
      end
      m_cnt  = 1;
      m_hcnt = 1;
    end else begin
      if (m_seen >= 1 && m_cnt == CNT_MAX) begin
        m_seen = 0;
        m_run  = 0;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
      if (v && m_hcnt < CNT_MAX) m_hcnt++;
    end
    m_prev = v;
  endtask

  task automatic run_pattern(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++)
        drive_cycle(j < hi);
  endtask

  initial begin
    bit seen_to;
    reset  = 1'b0;
    sig_in = 1'b0;
    model_reset();
    #12;
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);
    @(negedge clkin);
    reset = 1'b1;
    repeat (3) drive_cycle(0);

    run_pattern(3, 1, 8);
    check("div3_locked", locked, 1);

    run_pattern(5, 2, 6);
    run_pattern(6, 3, 6);
    check("p6_relocked", locked, 1);

    run_pattern(2, 1, 8);
    check("toggle_locked", locked, 1);

    // narrow unsampled pulse, then a missed rise
    run_pattern(4, 2, 6);
    drive_cycle(1); drive_cycle(1); drive_cycle(0); drive_cycle(0);
    #1 sig_in = 1'b1;
    #2 sig_in = 1'b0;
    repeat (4) drive_cycle(0);
    check("glitch_no_x", $isunknown({valid, locked, timeout, period, high_time}), 0);
    run_pattern(4, 2, 6);
    check("after_miss_locked", locked, 1);

    seen_to = 0;
    for (int k = 0; k < 400 && !seen_to; k++) begin
      drive_cycle(0);
      if (timeout === 1'b1) seen_to = 1;
    end
    check("timeout_seen", seen_to, 1);
    check("timeout_delay", cyc - last_valid_cyc, CNT_MAX);
    check("timeout_locked", locked, 0);
    check("timeout_period", period, 0);
    check("timeout_high_time", high_time, 0);
    run_pattern(4, 1, 3);
    check("timeout_cleared", timeout, 0);

    run_pattern(5, 2, 6);
    check("pre_reset_locked", locked, 1);
    check("pre_reset_sb_empty", sb.size(), 0);
    #3 reset = 1'b0;
    #1;
    check("midrst_period", period, 0);
    check("midrst_high_time", high_time, 0);
    check("midrst_valid", valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_timeout", timeout, 0);
    model_reset();
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    reset = 1'b1;
    run_pattern(5, 2, 4);

    repeat (10) drive_cycle(0);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
